bias_stream_sequencer: RTL and testbench
========================================

Name: bias_stream_sequencer

Overview:
Sequencer that drives a bias coefficient ROM (synchronous read, 1-cycle latency) and streams its contents into a downstream ap_fifo-style output stream. One start pulse replays the full bias vector NUM_PASSES times, e.g. once per output tile of a conv layer. A 2-entry skid buffer absorbs ROM latency under output backpressure and sustains 1 word/cycle. It replaces the HLS-generated bias streamer inside a layer's bias wrapper; the ROM instance stays outside this block.

Parameters:
COEFF_WIDTH, 16, bias word width (matches the coeff_width define)
NUM_BIAS, 16, ROM depth = bias words per pass (>=1)
NUM_PASSES, 4, passes per start (>=1)
ADDR_W, max(1,$clog2(NUM_BIAS)), ROM address width (derived)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  reset, asynchronous, active-high
ap_start  in  1  start request, sampled in IDLE only
ap_busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
ap_done  out  1  1-cycle pulse after the last word is transferred
bias_V_address0  out  ADDR_W  ROM read address
bias_V_ce0  out  1  ROM read enable; q valid the next cycle
bias_V_q0  in  COEFF_WIDTH  ROM read data
output_V_din  out  COEFF_WIDTH  stream data = skid-buffer head
output_V_full_n  in  1  downstream has space
output_V_write  out  1  transfer strobe

Behaviour:
- Reset (async, any time, including mid-pass): FSM to IDLE; all counters, buffer and in-flight flag cleared. Outputs 0: ap_busy, ap_done, bias_V_ce0, bias_V_address0, output_V_write, output_V_din. A ROM word in flight at reset is discarded.
- FSM states:
  - IDLE: on ap_start=1, clear counters and go to RUN.
  - RUN: issue reads and stream. Go to DONE when all NUM_BIAS*NUM_PASSES words are transferred.
  - DONE: ap_done=1 for one cycle, then IDLE.
- ap_start is ignored outside IDLE.
- Read issue: bias_V_ce0=1 in a RUN cycle when reads remain AND (occupancy + inflight - pop) < 2.
  - occupancy = skid entries 0..2; inflight = read issued last cycle; pop = this cycle's transfer.
  - The bias_V_address0 value presented with ce0=1 is the read address.
  - Address holds its value when ce0=0.
- Address counter: 0..NUM_BIAS-1 and wraps to 0. The pass counter increments on each wrap. No read is issued after read NUM_BIAS*NUM_PASSES.
- Capture: the cycle after an issued read, bias_V_q0 is written to the buffer tail. Order is preserved, and occupancy never exceeds 2 by construction.
- Output: output_V_write = (occupancy>0) & output_V_full_n & (state==RUN). A transfer (pop) happens exactly when output_V_write=1. output_V_din always shows the buffer head, or 0 when empty.
- Simultaneous capture and pop: both apply. Occupancy is unchanged and the head advances.
- full_n low: no writes. din holds the head and reads stop once the buffer plus in-flight read reaches 2. No data is lost or duplicated.
- Throughput and latency:
  - full_n held high: first write 2 cycles after the first ce0 (issue, capture, write), then 1 word/cycle.
  - Total RUN length = NUM_BIAS*NUM_PASSES + 2 cycles.
- Word counter: counts transfers. When it reaches NUM_BIAS*NUM_PASSES, go to DONE the next cycle, with ap_busy still high that cycle.
- Start back-to-back: ap_start held high re-triggers on the first IDLE cycle after DONE.

Test Plan:
- Basic stream: NUM_BIAS=4, NUM_PASSES=2, ROM={10,20,30,40}, full_n=1, start pulse -> addresses 0,1,2,3,0,1,2,3 on consecutive ce0 cycles; din sequence 10,20,30,40,10,20,30,40 on 8 consecutive write cycles; ap_done pulses once, 1 cycle after the 8th write.
- Backpressure: full_n low for 5 cycles starting on the 2nd write -> no write while low; at most 2 buffered plus no extra ce0; stream resumes with 30 and no loss or duplication.
- Toggle stress: full_n random 50% over NUM_BIAS=5, NUM_PASSES=3 -> the scoreboard sees exactly 15 words in ROM order with wrap; no write while full_n=0.
- Mid-operation reset: assert ap_rst asynchronously during pass 1 -> all outputs 0 immediately. A new start after release streams from address 0, pass 0, with no stale word emitted.
- Start while busy: ap_start pulses during RUN -> ignored; exactly one done and 8 words (basic config).
- Degenerate: NUM_BIAS=1, NUM_PASSES=1 -> one ce0 at address 0, one write, done; ap_busy high for exactly 4 cycles.

Source files
------------

// File: rtl/bias_stream_sequencer.sv
// bias_stream_sequencer
//
// Replays a bias coefficient ROM into an ap_fifo-style output stream.
// One accepted ap_start streams the whole bias vector NUM_PASSES times.
// A 2-entry skid buffer absorbs the 1-cycle ROM read latency, so the
// stream sustains one word per cycle and loses nothing under backpressure.
//
// Ports:
//   ap_clk, ap_rst     clock (rising edge), asynchronous active-high reset
//   ap_start           start request, sampled only while idle
//   ap_busy            high from the first RUN cycle through the done cycle
//   ap_done            one-cycle pulse after the last word is transferred
//   bias_V_address0    ROM read address (holds when no read is issued)
//   bias_V_ce0         ROM read enable; bias_V_q0 is valid the next cycle
//   bias_V_q0          ROM read data
//   output_V_din       skid-buffer head, 0 when the buffer is empty
//   output_V_full_n    downstream has space
//   output_V_write     transfer strobe
//
// Handshake: a word moves downstream in exactly the cycles where
// output_V_write=1, which requires a buffered word and output_V_full_n=1;
// din is stable while the head is waiting for space.
//
// The FSM state register is the signal 'state' (IDLE, RUN, DONE).

module bias_stream_sequencer #(
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_BIAS    = 16,
    parameter int NUM_PASSES  = 4,
    parameter int ADDR_W      = (NUM_BIAS > 1) ? $clog2(NUM_BIAS) : 1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ap_start,
    output logic                   ap_busy,
    output logic                   ap_done,
    output logic [ADDR_W-1:0]      bias_V_address0,
    output logic                   bias_V_ce0,
    input  logic [COEFF_WIDTH-1:0] bias_V_q0,
    output logic [COEFF_WIDTH-1:0] output_V_din,
    input  logic                   output_V_full_n,
    output logic                   output_V_write
);

    localparam int TOTAL  = NUM_BIAS * NUM_PASSES;
    localparam int WORD_W = $clog2(TOTAL + 1);
    localparam int PASS_W = $clog2(NUM_PASSES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]      addr_q;
    logic [PASS_W-1:0]      pass_q;
    logic [WORD_W-1:0]      word_q;
    logic [1:0]             occ_q;       // skid-buffer occupancy 0..2
    logic                   inflight_q;  // a read was issued last cycle
    logic [COEFF_WIDTH-1:0] head_q;
    logic [COEFF_WIDTH-1:0] tail_q;

    logic       reads_left;
    logic       addr_last;
    logic       pop;
    logic       issue;
    logic       last_word;
    logic [1:0] pending;

    // Words that will occupy the buffer next cycle before any new read:
    // occupancy plus the in-flight word. A pop this cycle frees one slot,
    // so a read may go out whenever pending - pop < 2.
    assign pending    = occ_q + {1'b0, inflight_q};
    assign reads_left = (pass_q != PASS_W'(NUM_PASSES));
    assign addr_last  = (addr_q == ADDR_W'(NUM_BIAS - 1));
    assign pop        = (state == ST_RUN) && (occ_q != 2'd0) && output_V_full_n;
    assign issue      = (state == ST_RUN) && reads_left
                        && (pending < (2'd2 + {1'b0, pop}));
    assign last_word  = pop && (word_q == WORD_W'(TOTAL - 1));

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs
    always_comb begin
        state_next      = state;
        ap_busy         = 1'b0;
        ap_done         = 1'b0;
        bias_V_ce0      = issue;
        bias_V_address0 = addr_q;
        output_V_write  = pop;
        output_V_din    = (occ_q != 2'd0) ? head_q : '0;
        case (state)
            ST_IDLE: begin
                if (ap_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                ap_busy = 1'b1;
                if (last_word) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ap_busy    = 1'b1;
                ap_done    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counters, in-flight flag and skid buffer
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            addr_q     <= '0;
            pass_q     <= '0;
            word_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else if ((state == ST_IDLE) && ap_start) begin
            addr_q     <= '0;
            pass_q     <= '0;
            word_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;

            if (issue) begin
                if (addr_last) begin
                    addr_q <= '0;
                    pass_q <= pass_q + PASS_W'(1);
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end

            if (pop) begin
                word_q <= word_q + WORD_W'(1);
            end

            // Capture of the in-flight ROM word and pop of the head.
            // Issue gating guarantees occupancy never exceeds 2.
            case ({inflight_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= bias_V_q0;
                    end else begin
                        tail_q <= bias_V_q0;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the head advances.
                    if (occ_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= bias_V_q0;
                    end else begin
                        head_q <= bias_V_q0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_stream_sequencer.sv
// Testbench for bias_stream_sequencer.
//
// Three instances with different geometries share clock and reset:
//   u0: NUM_BIAS=4, NUM_PASSES=2   u1: NUM_BIAS=5, NUM_PASSES=3
//   u2: NUM_BIAS=1, NUM_PASSES=1
// Only one instance is exercised at a time, so a single set of expected
// queues serves all of them. The reference model expands a start into the
// word and address sequence it must produce (passes x ROM contents); a
// negedge monitor pops and compares whenever an instance writes or reads.

module tb_bias_stream_sequencer;

    localparam int W = 16;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Stimulus
    logic         start  [3];
    logic         full_n [3];
    logic [W-1:0] rom    [3][16];

    // DUT outputs
    logic         busy  [3];
    logic         done  [3];
    logic         ce    [3];
    logic         write [3];
    logic [W-1:0] din   [3];
    logic [1:0]   a0;
    logic [2:0]   a1;
    logic [0:0]   a2;
    logic [W-1:0] q0, q1, q2;

    bias_stream_sequencer #(.COEFF_WIDTH(W), .NUM_BIAS(4), .NUM_PASSES(2)) u0 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start[0]), .ap_busy(busy[0]),
        .ap_done(done[0]), .bias_V_address0(a0), .bias_V_ce0(ce[0]),
        .bias_V_q0(q0), .output_V_din(din[0]), .output_V_full_n(full_n[0]),
        .output_V_write(write[0])
    );

    bias_stream_sequencer #(.COEFF_WIDTH(W), .NUM_BIAS(5), .NUM_PASSES(3)) u1 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start[1]), .ap_busy(busy[1]),
        .ap_done(done[1]), .bias_V_address0(a1), .bias_V_ce0(ce[1]),
        .bias_V_q0(q1), .output_V_din(din[1]), .output_V_full_n(full_n[1]),
        .output_V_write(write[1])
    );

    bias_stream_sequencer #(.COEFF_WIDTH(W), .NUM_BIAS(1), .NUM_PASSES(1)) u2 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start[2]), .ap_busy(busy[2]),
        .ap_done(done[2]), .bias_V_address0(a2), .bias_V_ce0(ce[2]),
        .bias_V_q0(q2), .output_V_din(din[2]), .output_V_full_n(full_n[2]),
        .output_V_write(write[2])
    );

    // Synchronous-read ROM models, one cycle latency
    always @(posedge clk) begin
        if (ce[0]) q0 <= rom[0][a0];
        if (ce[1]) q1 <= rom[1][a1];
        if (ce[2]) q2 <= rom[2][a2];
    end

    // Scoreboard state
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           exp_addr_q[$];
    int           run_len_q[$];

    int ce_cnt    [3];
    int wr_cnt    [3];
    int run_words [3];
    int busy_cyc  [3];
    int cur_len   [3];
    int done_cnt  [3];
    bit done_due  [3];
    bit bp_seen   [3];

    function automatic int nb_of(int g);
        case (g)
            0: return 4;
            1: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int np_of(int g);
        case (g)
            0: return 2;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int addr_of(int g);
        case (g)
            0: return int'(a0);
            1: return int'(a1);
            default: return int'(a2);
        endcase
    endfunction

    // Monitor step for one instance, run at every negedge
    task automatic mon_step(int g);
        logic [W-1:0] exp;
        int           ea;
        if (rst) begin
            ce_cnt[g] = 0; wr_cnt[g] = 0; run_words[g] = 0; busy_cyc[g] = 0;
            done_due[g] = 1'b0; bp_seen[g] = 1'b0;
            return;
        end
        // Done pulse exactly one cycle after the last word of a run
        if (done_due[g]) begin
            checks++;
            if (done[g] !== 1'b1) begin
                errors++;
                $display("FAIL done_pulse u%0d: got %0b, expected 1", g, done[g]);
            end
            checks++;
            if (busy[g] !== 1'b1) begin
                errors++;
                $display("FAIL busy_at_done u%0d: got %0b, expected 1", g, busy[g]);
            end
            if (!bp_seen[g]) begin
                checks++;
                if (busy_cyc[g] + 1 != cur_len[g] + 3) begin
                    errors++;
                    $display("FAIL busy_length u%0d: got %0d cycles, expected %0d",
                             g, busy_cyc[g] + 1, cur_len[g] + 3);
                end
            end
            done_due[g] = 1'b0; busy_cyc[g] = 0; bp_seen[g] = 1'b0;
            done_cnt[g]++;
        end else begin
            if (done[g]) begin
                checks++; errors++;
                $display("FAIL unexpected_done u%0d: got 1, expected 0", g);
            end
            if (busy[g]) begin
                busy_cyc[g]++;
                if (!full_n[g]) bp_seen[g] = 1'b1;
            end
        end
        // Output transfer
        if (write[g]) begin
            wr_cnt[g]++;
            checks++;
            if (!full_n[g]) begin
                errors++;
                $display("FAIL write_while_full u%0d: write=1 with full_n=0", g);
            end
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write u%0d: din=%0d, expected no write", g, din[g]);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (din[g] !== exp) begin
                    errors++;
                    $display("FAIL din u%0d: got %0d, expected %0d", g, din[g], exp);
                end
            end
            run_words[g]++;
            if (run_len_q.size() > 0 && run_words[g] == run_len_q[0]) begin
                cur_len[g]   = run_len_q.pop_front();
                run_words[g] = 0;
                done_due[g]  = 1'b1;
            end
        end
        // ROM read
        if (ce[g]) begin
            ce_cnt[g]++;
            checks++;
            if (ce_cnt[g] - wr_cnt[g] > 2) begin
                errors++;
                $display("FAIL outstanding u%0d: got %0d reads not yet written, expected <=2",
                         g, ce_cnt[g] - wr_cnt[g]);
            end
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read u%0d: address %0d, expected no read", g, addr_of(g));
            end else begin
                ea = exp_addr_q.pop_front();
                if (addr_of(g) != ea) begin
                    errors++;
                    $display("FAIL address u%0d: got %0d, expected %0d", g, addr_of(g), ea);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) mon_step(g);
    end

    // Reference model: one start = NUM_PASSES replays of the ROM in order
    task automatic push_run(int g);
        for (int p = 0; p < np_of(g); p++) begin
            for (int i = 0; i < nb_of(g); i++) begin
                exp_q.push_back(rom[g][i]);
                exp_addr_q.push_back(i);
            end
        end
        run_len_q.push_back(nb_of(g) * np_of(g));
    endtask

    task automatic flush_model();
        exp_q.delete();
        exp_addr_q.delete();
        run_len_q.delete();
    endtask

    // Driver tasks
    task automatic pulse_start(int g);
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
    endtask

    task automatic start_run(int g);
        push_run(g);
        pulse_start(g);
    endtask

    task automatic randomize_rom(int g);
        for (int i = 0; i < 16; i++) rom[g][i] = W'($urandom_range(0, 65535));
    endtask

    task automatic wait_done(int g, bit toggle);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (toggle) full_n[g] = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            if (exp_q.size() == 0 && run_len_q.size() == 0 && !done_due[g] && !busy[g]) begin
                full_n[g] = 1'b1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL timeout u%0d: run did not complete, %0d words outstanding", g, exp_q.size());
        full_n[g] = 1'b1;
        flush_model();
    endtask

    task automatic wait_writes(int g, int target);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); #1;
            if (wr_cnt[g] >= target) return;
        end
        checks++; errors++;
        $display("FAIL timeout_writes u%0d: got %0d writes, expected %0d", g, wr_cnt[g], target);
    endtask

    task automatic check_zero(int g);
        checks++;
        if (busy[g] !== 1'b0) begin errors++; $display("FAIL rst_busy u%0d: got %0b, expected 0", g, busy[g]); end
        checks++;
        if (done[g] !== 1'b0) begin errors++; $display("FAIL rst_done u%0d: got %0b, expected 0", g, done[g]); end
        checks++;
        if (ce[g] !== 1'b0) begin errors++; $display("FAIL rst_ce0 u%0d: got %0b, expected 0", g, ce[g]); end
        checks++;
        if (write[g] !== 1'b0) begin errors++; $display("FAIL rst_write u%0d: got %0b, expected 0", g, write[g]); end
        checks++;
        if (din[g] !== '0) begin errors++; $display("FAIL rst_din u%0d: got %0d, expected 0", g, din[g]); end
        checks++;
        if (addr_of(g) != 0) begin errors++; $display("FAIL rst_addr u%0d: got %0d, expected 0", g, addr_of(g)); end
    endtask

    // Main sequence
    initial begin
        int base;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start[g]  = 1'b0;
            full_n[g] = 1'b1;
            randomize_rom(g);
        end
        #2;
        for (int g = 0; g < 3; g++) check_zero(g);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Basic stream, known ROM contents
        for (int i = 0; i < 4; i++) rom[0][i] = W'((i + 1) * 10);
        start_run(0);
        wait_done(0, 1'b0);

        // Backpressure for 5 cycles right after the 2nd write
        base = wr_cnt[0];
        start_run(0);
        wait_writes(0, base + 2);
        @(posedge clk); #1 full_n[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 full_n[0] = 1'b1;
        wait_done(0, 1'b0);

        // Random full_n toggling with wrap across passes
        for (int r = 0; r < 3; r++) begin
            randomize_rom(1);
            start_run(1);
            wait_done(1, 1'b1);
        end
        randomize_rom(0);
        start_run(0);
        wait_done(0, 1'b1);

        // Asynchronous reset during pass 1, then a clean restart
        randomize_rom(0);
        base = wr_cnt[0];
        start_run(0);
        wait_writes(0, base + 5);
        @(posedge clk); #2 rst = 1'b1;
        #1 check_zero(0);
        flush_model();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        start_run(0);
        wait_done(0, 1'b0);

        // Start pulses while busy are ignored
        base = done_cnt[0];
        start_run(0);
        repeat (2) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            pulse_start(0);
        end
        wait_done(0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL restart_while_busy u0: busy=%0b after run, expected 0", busy[0]);
        end
        checks++;
        if (done_cnt[0] - base != 1) begin
            errors++;
            $display("FAIL done_count_busy_start u0: got %0d, expected 1", done_cnt[0] - base);
        end

        // ap_start held high re-triggers right after DONE
        base = done_cnt[0];
        push_run(0);
        push_run(0);
        @(posedge clk); #1 start[0] = 1'b1;
        for (int c = 0; c < 200 && done_cnt[0] == base; c++) begin
            @(negedge clk); #1;
        end
        @(posedge clk);
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0, 1'b0);
        checks++;
        if (done_cnt[0] - base != 2) begin
            errors++;
            $display("FAIL back_to_back u0: got %0d done pulses, expected 2", done_cnt[0] - base);
        end

        // Degenerate single-word instance
        randomize_rom(2);
        start_run(2);
        wait_done(2, 1'b0);
        randomize_rom(2);
        start_run(2);
        wait_done(2, 1'b1);

        // Nothing left unconsumed
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d words and %0d addresses remain, expected 0",
                     exp_q.size(), exp_addr_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
